// File: rtl/hdlc_rx_deframer.sv
// HDLC receive deframer: flag/abort hunting, zero destuffing and byte assembly.
// The 8-bit raw window delays data by 8 samples, so flag bits never reach the assembler.
module hdlc_rx_deframer (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       Rx,
  input  logic       RxEN,
  output logic [7:0] Rx_Data,
  output logic       Rx_NewByte,
  output logic       Rx_FlagDetect,
  output logic       Rx_AbortDetect,
  output logic       Rx_EoF,
  output logic       Rx_FrameError,
  output logic       Rx_ValidFrame,
  output logic       ZeroDetect
);

  typedef enum logic [0:0] {StIdle, StFrame} state_e;

  state_e      state_q;
  logic [2:0]  ones_q, ones_d;
  logic [7:0]  win_q, win_d;
  logic [7:0]  vld_q;
  logic [7:0]  stf_q;
  logic [7:0]  asm_q, asm_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  byte_cnt_q, byte_cnt_d;
  logic [7:0]  data_q;
  logic        new_byte_q, flag_det_q, abort_det_q, eof_q, ferr_q, valid_q, zero_q;
  logic        stuffed, flag_hit, abort_hit, consume, byte_done;

  always_comb begin
    stuffed    = !Rx && (ones_q == 3'd5);
    ones_d     = Rx ? ((ones_q == 3'd7) ? 3'd7 : ones_q + 3'd1) : 3'd0;
    win_d      = {win_q[6:0], Rx};
    flag_hit   = (win_d == 8'h7E) && (ones_q == 3'd6) && !Rx;
    abort_hit  = (state_q == StFrame) && Rx && (ones_q == 3'd6);
    // Exiting bit feeds the assembler only inside a frame and only if it is real data
    consume    = (state_q == StFrame) && vld_q[7] && !stf_q[7];
    asm_d      = consume ? {win_q[7], asm_q[7:1]} : asm_q;
    bit_cnt_d  = consume ? bit_cnt_q + 3'd1 : bit_cnt_q;
    byte_done  = consume && (bit_cnt_q == 3'd7);
    byte_cnt_d = (byte_done && (byte_cnt_q != 8'hFF)) ? byte_cnt_q + 8'd1 : byte_cnt_q;
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q     <= StIdle;
      ones_q      <= 3'd0;
      win_q       <= 8'h00;
      vld_q       <= 8'h00;
      stf_q       <= 8'h00;
      asm_q       <= 8'h00;
      bit_cnt_q   <= 3'd0;
      byte_cnt_q  <= 8'h00;
      data_q      <= 8'h00;
      new_byte_q  <= 1'b0;
      flag_det_q  <= 1'b0;
      abort_det_q <= 1'b0;
      eof_q       <= 1'b0;
      ferr_q      <= 1'b0;
      valid_q     <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      new_byte_q  <= 1'b0;
      flag_det_q  <= 1'b0;
      abort_det_q <= 1'b0;
      eof_q       <= 1'b0;
      ferr_q      <= 1'b0;
      zero_q      <= 1'b0;
      if (RxEN) begin
        ones_q     <= ones_d;
        win_q      <= win_d;
        vld_q      <= {vld_q[6:0], 1'b1};
        stf_q      <= {stf_q[6:0], stuffed};
        zero_q     <= stuffed;
        asm_q      <= asm_d;
        bit_cnt_q  <= bit_cnt_d;
        byte_cnt_q <= byte_cnt_d;
        if (byte_done) begin
          data_q     <= asm_d;
          new_byte_q <= 1'b1;
          valid_q    <= 1'b1;
        end
        unique case (state_q)
          StIdle: begin
            if (flag_hit) begin
              state_q    <= StFrame;
              flag_det_q <= 1'b1;
              bit_cnt_q  <= 3'd0;
              byte_cnt_q <= 8'h00;
              vld_q      <= 8'h00;
            end
          end
          StFrame: begin
            if (flag_hit) begin
              // Closing flag also opens the next frame, so the state is kept
              flag_det_q <= 1'b1;
              if (bit_cnt_d != 3'd0) begin
                ferr_q <= 1'b1;
              end else if (byte_cnt_d != 8'h00) begin
                eof_q <= 1'b1;
              end
              bit_cnt_q  <= 3'd0;
              byte_cnt_q <= 8'h00;
              vld_q      <= 8'h00;
              valid_q    <= 1'b0;
            end else if (abort_hit) begin
              abort_det_q <= 1'b1;
              vld_q       <= 8'h00;
              valid_q     <= 1'b0;
              state_q     <= StIdle;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign Rx_Data        = data_q;
  assign Rx_NewByte     = new_byte_q;
  assign Rx_FlagDetect  = flag_det_q;
  assign Rx_AbortDetect = abort_det_q;
  assign Rx_EoF         = eof_q;
  assign Rx_FrameError  = ferr_q;
  assign Rx_ValidFrame  = valid_q;
  assign ZeroDetect     = zero_q;

endmodule

// File: tb/tb_hdlc_rx_deframer.sv
// Bench for hdlc_rx_deframer: directed frames plus randomized traffic against a
// bit-queue reference model of the receive rules.
module tb_hdlc_rx_deframer;

  logic       Clk = 1'b0;
  logic       Rst;
  logic       Rx;
  logic       RxEN;
  logic [7:0] Rx_Data;
  logic       Rx_NewByte, Rx_FlagDetect, Rx_AbortDetect, Rx_EoF;
  logic       Rx_FrameError, Rx_ValidFrame, ZeroDetect;

  hdlc_rx_deframer dut (
    .Clk            (Clk),
    .Rst            (Rst),
    .Rx             (Rx),
    .RxEN           (RxEN),
    .Rx_Data        (Rx_Data),
    .Rx_NewByte     (Rx_NewByte),
    .Rx_FlagDetect  (Rx_FlagDetect),
    .Rx_AbortDetect (Rx_AbortDetect),
    .Rx_EoF         (Rx_EoF),
    .Rx_FrameError  (Rx_FrameError),
    .Rx_ValidFrame  (Rx_ValidFrame),
    .ZeroDetect     (ZeroDetect)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int         m_run;
  bit         m_in_frame;
  bit [1:0]   m_q[$];
  bit         m_acc[$];
  int         m_bytes;
  logic [7:0] m_data;
  bit         m_valid, m_nb, m_fl, m_ab, m_eof, m_fe, m_z;

  // Observation tallies
  int         n_nb, n_flag, n_abort, n_eof, n_ferr, n_zero, n_valid_hi, n_wide;
  int         mm_cnt, mm_cyc, cyc;
  logic [14:0] mm_obs, mm_exp;
  logic [5:0] prev_p;
  logic [7:0] obs_bytes[$];
  int         gap_mode;
  int         tx_run;

  task automatic model_step(input logic b, input logic en, input logic rst);
    m_nb = 0; m_fl = 0; m_ab = 0; m_eof = 0; m_fe = 0; m_z = 0;
    if (rst) begin
      m_run = 0; m_in_frame = 0; m_q.delete(); m_acc.delete();
      m_bytes = 0; m_data = 8'h00; m_valid = 0;
    end else if (en) begin
      bit stf, flg, abt;
      bit [1:0] e;
      stf = !b && (m_run == 5);
      flg = !b && (m_run == 6);
      abt = m_in_frame && b && (m_run == 6);
      m_run = b ? m_run + 1 : 0;
      m_z = stf;
      if (m_in_frame) begin
        m_q.push_back({stf, b});
        // A bit reaches the assembler once eight newer bits have arrived
        if (m_q.size() > 8) begin
          e = m_q.pop_front();
          if (!e[1]) begin
            m_acc.push_back(e[0]);
            if (m_acc.size() == 8) begin
              for (int k = 0; k < 8; k++) m_data[k] = m_acc[k];
              m_acc.delete();
              m_nb = 1;
              m_valid = 1;
              if (m_bytes < 255) m_bytes++;
            end
          end
        end
      end
      if (flg) begin
        m_fl = 1;
        if (m_in_frame) begin
          if (m_acc.size() != 0) m_fe = 1;
          else if (m_bytes >= 1) m_eof = 1;
        end
        m_valid = 0; m_in_frame = 1; m_q.delete(); m_acc.delete(); m_bytes = 0;
      end else if (abt) begin
        m_ab = 1; m_valid = 0; m_q.delete(); m_in_frame = 0;
      end
    end
  endtask

  task automatic step(input logic b, input logic en, input logic rst);
    logic [14:0] obs, expv;
    logic [5:0]  p;
    @(negedge Clk);
    Rx = b; RxEN = en; Rst = rst;
    @(posedge Clk);
    #1;
    model_step(b, en, rst);
    obs  = {Rx_Data, Rx_NewByte, Rx_FlagDetect, Rx_AbortDetect, Rx_EoF, Rx_FrameError,
            Rx_ValidFrame, ZeroDetect};
    expv = {m_data, m_nb, m_fl, m_ab, m_eof, m_fe, m_valid, m_z};
    if (obs !== expv) begin
      if (mm_cnt == 0) begin mm_cyc = cyc; mm_obs = obs; mm_exp = expv; end
      mm_cnt++;
    end
    cyc++;
    if (Rx_NewByte === 1'b1) begin n_nb++; obs_bytes.push_back(Rx_Data); end
    if (Rx_FlagDetect === 1'b1) n_flag++;
    if (Rx_AbortDetect === 1'b1) n_abort++;
    if (Rx_EoF === 1'b1) n_eof++;
    if (Rx_FrameError === 1'b1) n_ferr++;
    if (ZeroDetect === 1'b1) n_zero++;
    if (Rx_ValidFrame === 1'b1) n_valid_hi++;
    p = {Rx_NewByte, Rx_FlagDetect, Rx_AbortDetect, Rx_EoF, Rx_FrameError, ZeroDetect};
    if ((p & prev_p) != 6'd0) n_wide++;
    prev_p = p;
  endtask

  task automatic clear_obs();
    n_nb = 0; n_flag = 0; n_abort = 0; n_eof = 0; n_ferr = 0; n_zero = 0;
    n_valid_hi = 0; n_wide = 0; mm_cnt = 0; obs_bytes.delete(); prev_p = 6'd0;
  endtask

  task automatic do_reset();
    gap_mode = 0;
    step(1'b1, 1'b1, 1'b1);
  endtask

  task automatic send_bit(input logic b);
    if (gap_mode == 2) begin
      while ($urandom_range(0, 3) == 0) step(1'($urandom), 1'b0, 1'b0);
    end
    step(b, 1'b1, 1'b0);
    if (gap_mode == 1) step(1'($urandom), 1'b0, 1'b0);
  endtask

  task automatic send_ones(input int n);
    for (int i = 0; i < n; i++) send_bit(1'b1);
  endtask

  task automatic send_flag();
    logic [7:0] f;
    f = 8'h7E;
    for (int k = 0; k < 8; k++) send_bit(f[k]);
    tx_run = 0;
  endtask

  // Transmitter-side view: LSB first with a zero inserted after five 1s
  task automatic send_data(input logic [7:0] v);
    for (int k = 0; k < 8; k++) begin
      send_bit(v[k]);
      if (v[k]) begin
        tx_run++;
        if (tx_run == 5) begin send_bit(1'b0); tx_run = 0; end
      end else begin
        tx_run = 0;
      end
    end
  endtask

  function automatic logic [7:0] obs_byte(input int i);
    return (obs_bytes.size() > i) ? obs_bytes[i] : 8'hxx;
  endfunction

  task automatic test_reset();
    logic [14:0] o;
    clear_obs();
    do_reset();
    o = {Rx_Data, Rx_NewByte, Rx_FlagDetect, Rx_AbortDetect, Rx_EoF, Rx_FrameError,
         Rx_ValidFrame, ZeroDetect};
    checks++;
    if (o !== 15'd0) begin errors++; $display("FAIL reset_outputs: got %h, want 0", o); end
    send_ones(10);
    checks++;
    if (mm_cnt !== 0) begin
      errors++;
      $display("FAIL reset_model: %0d cycles differ, first cyc %0d got %h want %h",
               mm_cnt, mm_cyc, mm_obs, mm_exp);
    end
  endtask

  task automatic test_two_bytes();
    do_reset(); clear_obs();
    send_ones(16); send_flag(); send_data(8'hA5); send_data(8'h3C); send_flag();
    checks++; if (n_flag !== 2) begin errors++; $display("FAIL two_flags: got %0d, want 2", n_flag); end
    checks++; if (n_nb !== 2) begin errors++; $display("FAIL two_newbyte: got %0d, want 2", n_nb); end
    checks++; if (obs_byte(0) !== 8'hA5) begin errors++; $display("FAIL two_byte0: got %h, want a5", obs_byte(0)); end
    checks++; if (obs_byte(1) !== 8'h3C) begin errors++; $display("FAIL two_byte1: got %h, want 3c", obs_byte(1)); end
    checks++; if (n_eof !== 1) begin errors++; $display("FAIL two_eof: got %0d, want 1", n_eof); end
    checks++; if (n_ferr !== 0) begin errors++; $display("FAIL two_ferr: got %0d, want 0", n_ferr); end
    checks++; if (n_valid_hi !== 8) begin errors++; $display("FAIL two_valid_cycles: got %0d, want 8", n_valid_hi); end
    checks++;
    if (mm_cnt !== 0) begin
      errors++;
      $display("FAIL two_model: %0d cycles differ, first cyc %0d got %h want %h",
               mm_cnt, mm_cyc, mm_obs, mm_exp);
    end
  endtask

  task automatic test_stuffing();
    do_reset(); clear_obs();
    send_flag(); send_data(8'hFF); send_flag();
    checks++; if (n_zero !== 1) begin errors++; $display("FAIL stuff_zero: got %0d, want 1", n_zero); end
    checks++; if (n_nb !== 1) begin errors++; $display("FAIL stuff_newbyte: got %0d, want 1", n_nb); end
    checks++; if (obs_byte(0) !== 8'hFF) begin errors++; $display("FAIL stuff_byte: got %h, want ff", obs_byte(0)); end
    checks++; if (n_eof !== 1) begin errors++; $display("FAIL stuff_eof: got %0d, want 1", n_eof); end
    checks++;
    if (mm_cnt !== 0) begin
      errors++;
      $display("FAIL stuff_model: %0d cycles differ, first cyc %0d got %h want %h",
               mm_cnt, mm_cyc, mm_obs, mm_exp);
    end
  endtask

  task automatic test_abort();
    do_reset(); clear_obs();
    // One spacer bit lets the last data bit drain from the 8-deep window on the abort edge
    send_flag(); send_data(8'h12); send_bit(1'b0); send_ones(8);
    checks++; if (n_nb !== 1) begin errors++; $display("FAIL abort_newbyte: got %0d, want 1", n_nb); end
    checks++; if (obs_byte(0) !== 8'h12) begin errors++; $display("FAIL abort_byte: got %h, want 12", obs_byte(0)); end
    checks++; if (n_abort !== 1) begin errors++; $display("FAIL abort_count: got %0d, want 1", n_abort); end
    checks++; if (Rx_ValidFrame !== 1'b0) begin errors++; $display("FAIL abort_valid: got %b, want 0", Rx_ValidFrame); end
    send_ones(8); send_flag(); send_data(8'h33); send_flag();
    checks++; if (n_abort !== 1) begin errors++; $display("FAIL abort_idle_ones: got %0d, want 1", n_abort); end
    checks++; if (n_eof !== 1) begin errors++; $display("FAIL abort_restart_eof: got %0d, want 1", n_eof); end
    checks++; if (obs_byte(1) !== 8'h33) begin errors++; $display("FAIL abort_restart_byte: got %h, want 33", obs_byte(1)); end
    checks++;
    if (mm_cnt !== 0) begin
      errors++;
      $display("FAIL abort_model: %0d cycles differ, first cyc %0d got %h want %h",
               mm_cnt, mm_cyc, mm_obs, mm_exp);
    end
  endtask

  task automatic test_frame_error();
    do_reset(); clear_obs();
    send_flag(); send_data(8'h81); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_flag();
    checks++; if (n_nb !== 1) begin errors++; $display("FAIL ferr_newbyte: got %0d, want 1", n_nb); end
    checks++; if (obs_byte(0) !== 8'h81) begin errors++; $display("FAIL ferr_byte: got %h, want 81", obs_byte(0)); end
    checks++; if (n_ferr !== 1) begin errors++; $display("FAIL ferr_count: got %0d, want 1", n_ferr); end
    checks++; if (n_eof !== 0) begin errors++; $display("FAIL ferr_eof: got %0d, want 0", n_eof); end
    checks++;
    if (mm_cnt !== 0) begin
      errors++;
      $display("FAIL ferr_model: %0d cycles differ, first cyc %0d got %h want %h",
               mm_cnt, mm_cyc, mm_obs, mm_exp);
    end
  endtask

  task automatic test_back_to_back();
    for (int pass = 0; pass < 2; pass++) begin
      do_reset(); clear_obs();
      gap_mode = pass;
      send_flag(); send_flag(); send_flag();
      checks++; if (n_flag !== 3) begin errors++; $display("FAIL b2b_flags pass %0d: got %0d, want 3", pass, n_flag); end
      checks++; if (n_eof !== 0) begin errors++; $display("FAIL b2b_eof pass %0d: got %0d, want 0", pass, n_eof); end
      checks++; if (n_valid_hi !== 0) begin errors++; $display("FAIL b2b_valid pass %0d: got %0d, want 0", pass, n_valid_hi); end
      checks++; if (n_wide !== 0) begin errors++; $display("FAIL b2b_width pass %0d: got %0d, want 0", pass, n_wide); end
      checks++;
      if (mm_cnt !== 0) begin
        errors++;
        $display("FAIL b2b_model pass %0d: %0d cycles differ, first cyc %0d got %h want %h",
                 pass, mm_cnt, mm_cyc, mm_obs, mm_exp);
      end
    end
    gap_mode = 0;
  endtask

  task automatic test_reset_mid_frame();
    logic [14:0] o;
    do_reset(); clear_obs();
    send_flag(); send_data(8'h5A); send_data(8'hC3);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    step(1'b0, 1'b1, 1'b1);
    o = {Rx_Data, Rx_NewByte, Rx_FlagDetect, Rx_AbortDetect, Rx_EoF, Rx_FrameError,
         Rx_ValidFrame, ZeroDetect};
    checks++; if (o !== 15'd0) begin errors++; $display("FAIL midrst_outputs: got %h, want 0", o); end
    send_ones(12);
    checks++; if (n_nb !== 1) begin errors++; $display("FAIL midrst_newbyte: got %0d, want 1", n_nb); end
    checks++; if (obs_byte(0) !== 8'h5A) begin errors++; $display("FAIL midrst_byte: got %h, want 5a", obs_byte(0)); end
    checks++; if ((n_eof + n_abort) !== 0) begin errors++; $display("FAIL midrst_eof_abort: got %0d, want 0", n_eof + n_abort); end
    checks++;
    if (mm_cnt !== 0) begin
      errors++;
      $display("FAIL midrst_model: %0d cycles differ, first cyc %0d got %h want %h",
               mm_cnt, mm_cyc, mm_obs, mm_exp);
    end
  endtask

  task automatic test_random();
    int nbytes, kind, nextra;
    logic [7:0] v;
    do_reset(); clear_obs();
    gap_mode = 2;
    for (int f = 0; f < 40; f++) begin
      send_flag();
      nbytes = $urandom_range(0, 4);
      for (int i = 0; i < nbytes; i++) begin
        v = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
        send_data(v);
      end
      kind = $urandom_range(0, 3);
      if (kind == 0) begin
        nextra = $urandom_range(1, 7);
        for (int k = 0; k < nextra; k++) send_bit(1'($urandom));
      end else if (kind == 1) begin
        send_ones($urandom_range(7, 9));
        send_ones(3);
      end
    end
    send_flag();
    gap_mode = 0;
    checks++; if (n_nb == 0) begin errors++; $display("FAIL rand_newbyte: got %0d, want >0", n_nb); end
    checks++;
    if (mm_cnt !== 0) begin
      errors++;
      $display("FAIL rand_model: %0d cycles differ, first cyc %0d got %h want %h",
               mm_cnt, mm_cyc, mm_obs, mm_exp);
    end
  endtask

  initial begin
    Rst = 1'b1; Rx = 1'b1; RxEN = 1'b0;
    gap_mode = 0; tx_run = 0; cyc = 0;
    model_step(1'b1, 1'b1, 1'b1);
    clear_obs();
    test_reset();
    test_two_bytes();
    test_stuffing();
    test_abort();
    test_frame_error();
    test_back_to_back();
    test_reset_mid_frame();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

endmodule
